// File: rtl/cpu_io_pkg.sv
// ---------------------------------------------------------------------------
// cpu_io_pkg
// Shared definitions for the CPU I/O bridge:
//   - default data width and egress FIFO depth
//   - ingress holding-register FSM state encoding
//   - helper that sizes a 0..depth occupancy counter
// ---------------------------------------------------------------------------
package cpu_io_pkg;

    localparam int DATA_W_DEFAULT    = 16;
    localparam int OUT_DEPTH_DEFAULT = 4;

    // Ingress holding register: EMPTY waits for a word, FULL holds one for the CPU.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } in_state_e;

    // A counter that must reach `depth` itself needs one bit more than a pointer.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage : cpu_io_pkg

// File: rtl/io_sync_fifo.sv
// ---------------------------------------------------------------------------
// io_sync_fifo
// Single-clock FIFO used as the bridge egress buffer. No same-cycle bypass:
// a pushed word becomes visible on rd_data the cycle after the push.
// A push while full is refused even if a pop happens in the same cycle.
//
// Parameters:
//   DATA_W  word width
//   DEPTH   number of entries; power of two, at least 2
// Ports:
//   clk      clock, rising edge
//   rst_n    asynchronous active-low reset (pointers and count only)
//   push     write request; accepted when count < DEPTH
//   wr_data  word to write
//   pop      read request; accepted when count != 0
//   rd_data  head entry, 0 while empty
//   full     count == DEPTH
//   count    occupancy 0..DEPTH
// ---------------------------------------------------------------------------
module io_sync_fifo
    import cpu_io_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DEPTH  = OUT_DEPTH_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic                      pop,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      full,
    output logic [cnt_w(DEPTH)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push_ok;
    logic              pop_ok;
    logic              empty;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Gating the read port keeps egress data at 0 while empty (and in reset)
    // without needing to clear the storage array.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // NOTE: storage has no reset; only pointers/count define which entries are live.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so natural overflow is the modulo wrap.
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule : io_sync_fifo

// File: rtl/cpu_io_bridge.sv
// ---------------------------------------------------------------------------
// cpu_io_bridge
// Connects a CPU's strobed output/input ports to valid/ready streams.
//   Egress : cpu_wr pushes cpu_dout into an OUT_DEPTH-word FIFO drained on
//            out_valid/out_ready.
//   Ingress: a single holding register, filled on in_valid/in_ready and
//            consumed by cpu_rd.
// cpu_stall tells the CPU to hold its strobe and data and retry next cycle.
//
// Optional build macro CPU_IO_BRIDGE_STATUS_EN adds:
//   out_level  egress FIFO occupancy
//   wr_drop    sticky flag: a cpu_wr was seen while the FIFO was full
//
// Ports:
//   clk        clock, rising edge
//   sys_rst    asynchronous active-low reset
//   cpu_dout   CPU output-port word       cpu_wr    CPU write strobe
//   cpu_rd     CPU read strobe            cpu_din   word presented to CPU
//   cpu_stall  CPU must retry this strobe
//   out_data / out_valid / out_ready      egress stream
//   in_data  / in_valid  / in_ready       ingress stream
// ---------------------------------------------------------------------------
module cpu_io_bridge
    import cpu_io_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEFAULT,
    parameter int OUT_DEPTH = OUT_DEPTH_DEFAULT
) (
    input  logic                          clk,
    input  logic                          sys_rst,
    input  logic [DATA_W-1:0]             cpu_dout,
    input  logic                          cpu_wr,
    input  logic                          cpu_rd,
    output logic [DATA_W-1:0]             cpu_din,
    output logic                          cpu_stall,
    output logic [DATA_W-1:0]             out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    input  logic [DATA_W-1:0]             in_data,
    input  logic                          in_valid,
    output logic                          in_ready
`ifdef CPU_IO_BRIDGE_STATUS_EN
    ,
    output logic [cnt_w(OUT_DEPTH)-1:0]   out_level,
    output logic                          wr_drop
`endif
);

    localparam int CNT_W = cnt_w(OUT_DEPTH);

    // ---------------- egress ----------------
    logic             fifo_full;
    logic [CNT_W-1:0] fifo_count;

    io_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (OUT_DEPTH)
    ) u_out_fifo (
        .clk     (clk),
        .rst_n   (sys_rst),
        .push    (cpu_wr),
        .wr_data (cpu_dout),
        .pop     (out_ready),
        .rd_data (out_data),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    assign out_valid = (fifo_count != '0);

    // ---------------- ingress ----------------
    in_state_e         state;
    in_state_e         state_next;
    logic              in_xfer;
    logic [DATA_W-1:0] hold_q;

    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no latches form.
    always_comb begin
        state_next = state;
        // A read in the same cycle frees the register, so a new word can land
        // while the old one is being consumed.
        in_ready   = (state == ST_EMPTY) || cpu_rd;
        in_xfer    = in_valid && in_ready;
        case (state)
            ST_EMPTY: if (in_xfer) state_next = ST_FULL;
            ST_FULL:  if (cpu_rd && !in_xfer) state_next = ST_EMPTY;
            default:  state_next = ST_EMPTY;
        endcase
    end

    // Holds its value while EMPTY so cpu_din keeps showing the last word.
    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            hold_q <= '0;
        end else if (in_xfer) begin
            hold_q <= in_data;
        end
    end

    assign cpu_din   = hold_q;
    assign cpu_stall = (cpu_wr && fifo_full) || (cpu_rd && (state == ST_EMPTY));

    // ---------------- optional status ----------------
`ifdef CPU_IO_BRIDGE_STATUS_EN
    assign out_level = fifo_count;

    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            wr_drop <= 1'b0;
        end else if (cpu_wr && fifo_full) begin
            wr_drop <= 1'b1;
        end
    end
`endif

endmodule : cpu_io_bridge

// File: tb/tb_cpu_io_bridge.sv
// ---------------------------------------------------------------------------
// tb_cpu_io_bridge
// Directed bench for cpu_io_bridge (DATA_W=16, OUT_DEPTH=4). Inputs change
// 1 time unit after the rising edge; outputs are sampled 1 unit later.
// ---------------------------------------------------------------------------
module tb_cpu_io_bridge;

    logic        clk = 1'b0;
    logic        sys_rst;
    logic [15:0] cpu_dout;
    logic        cpu_wr;
    logic        cpu_rd;
    logic [15:0] cpu_din;
    logic        cpu_stall;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
`ifdef CPU_IO_BRIDGE_STATUS_EN
    logic [2:0]  out_level;
    logic        wr_drop;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cpu_io_bridge #(.DATA_W(16), .OUT_DEPTH(4)) dut (
        .clk       (clk),
        .sys_rst   (sys_rst),
        .cpu_dout  (cpu_dout),
        .cpu_wr    (cpu_wr),
        .cpu_rd    (cpu_rd),
        .cpu_din   (cpu_din),
        .cpu_stall (cpu_stall),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready)
`ifdef CPU_IO_BRIDGE_STATUS_EN
        ,
        .out_level (out_level),
        .wr_drop   (wr_drop)
`endif
    );

    // Advance to 1 unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        sys_rst = 1'b0; cpu_wr = 1'b0; cpu_rd = 1'b0; cpu_dout = '0;
        out_ready = 1'b0; in_valid = 1'b0; in_data = '0;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 16'h0000) begin failures++; $display("FAIL rst_out_data got=%h exp=0000", out_data); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        checks++; if (cpu_din !== 16'h0000) begin failures++; $display("FAIL rst_cpu_din got=%h exp=0000", cpu_din); end
        checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL rst_stall_idle got=%b exp=0", cpu_stall); end
        // Stall is still combinational in reset: a read with nothing held stalls.
        cpu_rd = 1'b1;
        #1;
        checks++; if (cpu_stall !== 1'b1) begin failures++; $display("FAIL rst_stall_rd got=%b exp=1", cpu_stall); end
        cpu_rd = 1'b0;
        #2;
        sys_rst = 1'b1;
        tick();
    endtask

    task automatic test_single_write();
        cpu_wr = 1'b1; cpu_dout = 16'hAAAA; out_ready = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL sw_no_bypass got=%b exp=0", out_valid); end
        checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL sw_stall got=%b exp=0", cpu_stall); end
        tick();
        cpu_wr = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL sw_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 16'hAAAA) begin failures++; $display("FAIL sw_data got=%h exp=aaaa", out_data); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL sw_drained got=%b exp=0", out_valid); end
    endtask

    task automatic test_fill_stall();
        logic [15:0] exp_order [4];
        exp_order[0] = 16'h0003; exp_order[1] = 16'h0004;
        exp_order[2] = 16'h0005; exp_order[3] = 16'h0000;
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cpu_wr = 1'b1; cpu_dout = 16'(i);
            #1;
            checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL fill_stall_%0d got=%b exp=0", i, cpu_stall); end
            tick();
        end
        cpu_dout = 16'h0005;
        #1;
        checks++; if (cpu_stall !== 1'b1) begin failures++; $display("FAIL full_stall got=%b exp=1", cpu_stall); end
        checks++; if (out_data !== 16'h0001) begin failures++; $display("FAIL full_head got=%h exp=0001", out_data); end
        tick();
`ifdef CPU_IO_BRIDGE_STATUS_EN
        checks++; if (out_level !== 3'd4) begin failures++; $display("FAIL full_level got=%0d exp=4", out_level); end
        checks++; if (wr_drop !== 1'b1) begin failures++; $display("FAIL wr_drop_set got=%b exp=1", wr_drop); end
`endif
        // Retry while still full but draining: refused again.
        out_ready = 1'b1;
        #1;
        checks++; if (cpu_stall !== 1'b1) begin failures++; $display("FAIL full_pop_stall got=%b exp=1", cpu_stall); end
        checks++; if (out_data !== 16'h0001) begin failures++; $display("FAIL egress_0 got=%h exp=0001", out_data); end
        tick();
        #1;
        checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL retry_stall got=%b exp=0", cpu_stall); end
        checks++; if (out_data !== 16'h0002) begin failures++; $display("FAIL egress_1 got=%h exp=0002", out_data); end
        tick();
        cpu_wr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (out_data !== exp_order[i]) begin failures++; $display("FAIL egress_%0d got=%h exp=%h", i + 2, out_data, exp_order[i]); end
            checks++; if (out_valid !== (i < 3)) begin failures++; $display("FAIL egress_valid_%0d got=%b exp=%b", i + 2, out_valid, (i < 3)); end
            tick();
        end
    endtask

    task automatic test_read();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'h5555;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rd_in_ready_empty got=%b exp=1", in_ready); end
        tick();
        in_valid = 1'b0; cpu_rd = 1'b1;
        #1;
        checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL rd1_stall got=%b exp=0", cpu_stall); end
        checks++; if (cpu_din !== 16'h5555) begin failures++; $display("FAIL rd1_din got=%h exp=5555", cpu_din); end
        tick();
        #1;
        checks++; if (cpu_stall !== 1'b1) begin failures++; $display("FAIL rd2_stall got=%b exp=1", cpu_stall); end
        checks++; if (cpu_din !== 16'h5555) begin failures++; $display("FAIL rd2_din_kept got=%h exp=5555", cpu_din); end
        tick();
        cpu_rd = 1'b0;
    endtask

    task automatic test_read_reload();
        in_valid = 1'b1; in_data = 16'hBEEF;
        tick();
        in_valid = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rl_in_ready_full got=%b exp=0", in_ready); end
        in_valid = 1'b1; in_data = 16'h1234; cpu_rd = 1'b1;
        #1;
        checks++; if (cpu_din !== 16'hBEEF) begin failures++; $display("FAIL rl_old_word got=%h exp=beef", cpu_din); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rl_in_ready_rd got=%b exp=1", in_ready); end
        checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL rl_stall got=%b exp=0", cpu_stall); end
        tick();
        in_valid = 1'b0; cpu_rd = 1'b0;
        #1;
        checks++; if (cpu_din !== 16'h1234) begin failures++; $display("FAIL rl_new_word got=%h exp=1234", cpu_din); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rl_still_full got=%b exp=0", in_ready); end
        cpu_rd = 1'b1;
        tick();
        cpu_rd = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rl_emptied got=%b exp=1", in_ready); end
    endtask

    task automatic test_simultaneous();
        in_valid = 1'b1; in_data = 16'h0F0F;
        tick();
        in_valid = 1'b0;
        cpu_wr = 1'b1; cpu_dout = 16'hC3C3; cpu_rd = 1'b1; out_ready = 1'b1;
        #1;
        checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL sim_stall got=%b exp=0", cpu_stall); end
        checks++; if (cpu_din !== 16'h0F0F) begin failures++; $display("FAIL sim_din got=%h exp=0f0f", cpu_din); end
        tick();
        cpu_wr = 1'b0; cpu_rd = 1'b0;
        #1;
        checks++; if (out_data !== 16'hC3C3) begin failures++; $display("FAIL sim_out_data got=%h exp=c3c3", out_data); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL sim_in_empty got=%b exp=1", in_ready); end
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cpu_wr = 1'b1; cpu_dout = 16'hA1 + 16'(i);
            in_valid = (i == 0); in_data = 16'h7777;
            tick();
        end
        cpu_wr = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL pre_rst_valid got=%b exp=1", out_valid); end
        checks++; if (cpu_din !== 16'h7777) begin failures++; $display("FAIL pre_rst_din got=%h exp=7777", cpu_din); end
`ifdef CPU_IO_BRIDGE_STATUS_EN
        checks++; if (out_level !== 3'd3) begin failures++; $display("FAIL pre_rst_level got=%0d exp=3", out_level); end
`endif
        #2;
        sys_rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 16'h0000) begin failures++; $display("FAIL mid_rst_data got=%h exp=0000", out_data); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_in_ready got=%b exp=1", in_ready); end
        checks++; if (cpu_din !== 16'h0000) begin failures++; $display("FAIL mid_rst_din got=%h exp=0000", cpu_din); end
`ifdef CPU_IO_BRIDGE_STATUS_EN
        checks++; if (out_level !== 3'd0) begin failures++; $display("FAIL mid_rst_level got=%0d exp=0", out_level); end
        checks++; if (wr_drop !== 1'b0) begin failures++; $display("FAIL mid_rst_drop got=%b exp=0", wr_drop); end
`endif
        #2;
        sys_rst = 1'b1;
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL post_rst_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_rst_in_ready got=%b exp=1", in_ready); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_fill_stall();
        test_read();
        test_read_reload();
        test_simultaneous();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_cpu_io_bridge
